// File: rtl/capture_cntrl_pm.sv
// Capture controller: sequences sample writes into the per-channel trace RAMs around a trigger,
// with clamped trigger position, latched channel mask, recorded trace end and optional auto re-arm.
module capture_cntrl_pm #(
   parameter int ENTRIES = 384,
   parameter int AW      = $clog2(ENTRIES),
   parameter int NUM_CH  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wrt_smpl,
   input  logic              run,
   input  logic              capture_done,
   input  logic              triggered,
   input  logic [7:0]        trig_posH,
   input  logic [7:0]        trig_posL,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              auto_rearm,
   output logic [NUM_CH-1:0] we,
   output logic [AW-1:0]     waddr,
   output logic              armed,
   output logic              set_capture_done,
   output logic [AW-1:0]     trace_end
);

   typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_t;

   localparam logic [AW-1:0] LAST = AW'(ENTRIES - 1);
   localparam logic [AW-1:0] ONE  = AW'(1);

   state_t            state;
   logic [AW-1:0]     tp_eff;
   logic [AW-1:0]     tp_clamped;
   logic [AW-1:0]     pre_depth;
   logic [AW-1:0]     pre_cnt;
   logic [AW-1:0]     post_cnt;
   logic [AW-1:0]     waddr_next;
   logic [NUM_CH-1:0] ch_en_q;
   logic [15:0]       tp_raw;
   logic              ack_seen;
   logic              wr_ok;
   logic              start_pre;
   logic              pre_hit;
   logic              last_write;

   // A zero post-trigger count would never finish, and ENTRIES or more would leave no pre-trigger room.
   always_comb begin
      tp_raw = {trig_posH, trig_posL};
      if (tp_raw == 16'd0)
         tp_clamped = ONE;
      else if (tp_raw > 16'(ENTRIES - 1))
         tp_clamped = LAST;
      else
         tp_clamped = AW'(tp_raw);
   end

   always_comb begin
      pre_depth  = LAST - tp_eff + ONE;
      waddr_next = (waddr == LAST) ? '0 : waddr + ONE;
      wr_ok      = wrt_smpl && run && (state == PRE || state == ARMED || state == POST);
      we         = wr_ok ? ch_en_q : '0;
      start_pre  = (state == IDLE && run) ||
                   (state == DONE && ack_seen && !capture_done && auto_rearm && run);
      pre_hit    = wr_ok && state == PRE && (pre_cnt + ONE == pre_depth);
      last_write = wr_ok && ((state == ARMED && triggered && tp_eff == ONE) ||
                             (state == POST && post_cnt + ONE == tp_eff));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         waddr            <= '0;
         armed            <= 1'b0;
         set_capture_done <= 1'b0;
         trace_end        <= '0;
         pre_cnt          <= '0;
         post_cnt         <= '0;
         tp_eff           <= ONE;
         ch_en_q          <= '0;
         ack_seen         <= 1'b0;
      end else begin
         set_capture_done <= 1'b0;
         if (start_pre) begin
            state    <= PRE;
            waddr    <= '0;
            pre_cnt  <= '0;
            post_cnt <= '0;
            tp_eff   <= tp_clamped;
            ch_en_q  <= ch_en;
            ack_seen <= 1'b0;
         end else begin
            case (state)
               PRE, ARMED, POST: begin
                  if (!run) begin
                     state <= IDLE;
                     armed <= 1'b0;
                  end else if (wr_ok) begin
                     waddr <= waddr_next;
                     if (last_write) begin
                        state            <= DONE;
                        armed            <= 1'b0;
                        set_capture_done <= 1'b1;
                        trace_end        <= waddr;
                     end else if (state == PRE) begin
                        pre_cnt <= pre_cnt + ONE;
                        if (pre_hit) begin
                           state <= ARMED;
                           armed <= 1'b1;
                        end
                     end else if (state == ARMED) begin
                        if (triggered) begin
                           post_cnt <= ONE;
                           state    <= POST;
                        end
                     end else begin
                        post_cnt <= post_cnt + ONE;
                     end
                  end
               end
               // The host must be seen raising then dropping capture_done before we leave.
               DONE: begin
                  if (capture_done)
                     ack_seen <= 1'b1;
                  else if (ack_seen) begin
                     ack_seen <= 1'b0;
                     state    <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_capture_cntrl_pm.sv
// Self-checking bench for capture_cntrl_pm: table-driven capture vectors plus abort/reset sequences,
// with write strobes checked through an expected-write scoreboard.
module tb_capture_cntrl_pm;

   localparam int ENTRIES = 384;
   localparam int AW      = 9;
   localparam int NUM_CH  = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              wrt_smpl;
   logic              run;
   logic              capture_done;
   logic              triggered;
   logic [7:0]        trig_posH;
   logic [7:0]        trig_posL;
   logic [NUM_CH-1:0] ch_en;
   logic              auto_rearm;
   logic [NUM_CH-1:0] we;
   logic [AW-1:0]     waddr;
   logic              armed;
   logic              set_capture_done;
   logic [AW-1:0]     trace_end;

   typedef struct {
      logic [15:0]       trig_pos;
      logic [NUM_CH-1:0] ch_mask;
      int                trig_idx;
      int                pre_depth;
      int                total;
      int                trace_end_exp;
      bit                rearm;
   } vec_t;

   typedef struct {
      logic [NUM_CH-1:0] we_exp;
      logic [AW-1:0]     addr_exp;
   } exp_t;

   exp_t sb_queue[$];
   vec_t vecs[5];
   int   compared   = 0;
   int   mismatched = 0;
   bit   started    = 1'b0;

   capture_cntrl_pm #(.ENTRIES(ENTRIES), .AW(AW), .NUM_CH(NUM_CH)) dut (
      .clk              (clk),
      .rst              (rst),
      .wrt_smpl         (wrt_smpl),
      .run              (run),
      .capture_done     (capture_done),
      .triggered        (triggered),
      .trig_posH        (trig_posH),
      .trig_posL        (trig_posL),
      .ch_en            (ch_en),
      .auto_rearm       (auto_rearm),
      .we               (we),
      .waddr            (waddr),
      .armed            (armed),
      .set_capture_done (set_capture_done),
      .trace_end        (trace_end)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Write strobes are judged mid-cycle against what the driver queued for that cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sb_queue.size() > 0) begin
         e = sb_queue.pop_front();
         checkOutput("we", int'(we), int'(e.we_exp));
         if (e.we_exp != '0)
            checkOutput("waddr", int'(waddr), int'(e.addr_exp));
      end else if (started) begin
         checkOutput("we_quiet", int'(we), 0);
      end
   end

   task automatic applyStimulus(input bit wr, input bit trig,
                                input logic [NUM_CH-1:0] we_exp, input logic [AW-1:0] addr_exp);
      exp_t e;
      wrt_smpl  = wr;
      triggered = trig;
      if (wr) begin
         e.we_exp   = we_exp;
         e.addr_exp = addr_exp;
         sb_queue.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic setParams(input logic [15:0] tp, input logic [NUM_CH-1:0] mask);
      {trig_posH, trig_posL} = tp;
      ch_en = mask;
   endtask

   // Starts already in PRE; mask and trigger position are scrambled throughout to prove they were latched.
   task automatic runCapture(input vec_t v);
      int writes = 0;
      int cyc    = 0;
      bit done   = 1'b0;
      while (!done && cyc < 4000) begin
         bit w;
         w = ($urandom_range(0, 3) != 0);
         ch_en = NUM_CH'($urandom);
         {trig_posH, trig_posL} = 16'($urandom);
         applyStimulus(w, writes >= v.trig_idx, w ? v.ch_mask : '0, AW'(writes % ENTRIES));
         if (w)
            writes++;
         cyc++;
         if (writes == v.total) begin
            checkOutput("done_pulse", int'(set_capture_done), 1);
            checkOutput("trace_end", int'(trace_end), v.trace_end_exp);
            checkOutput("armed_at_done", int'(armed), 0);
            done = 1'b1;
         end else begin
            checkOutput("armed", int'(armed), int'(writes >= v.pre_depth));
            checkOutput("early_pulse", int'(set_capture_done), 0);
         end
      end
      if (!done)
         checkOutput("capture_timeout_writes", writes, v.total);
   endtask

   task automatic handshake(input bit rearm, input int te);
      auto_rearm = 1'b1;
      repeat (6) begin
         applyStimulus(1'b1, 1'b0, '0, '0);
         checkOutput("pulse_width", int'(set_capture_done), 0);
         checkOutput("hold_trace_end", int'(trace_end), te);
      end
      auto_rearm   = rearm;
      capture_done = 1'b1;
      applyStimulus(1'b1, 1'b0, '0, '0);
      applyStimulus(1'b1, 1'b0, '0, '0);
      capture_done = 1'b0;
      applyStimulus(1'b1, 1'b0, '0, '0);
      if (rearm) begin
         checkOutput("rearm_waddr", int'(waddr), 0);
      end else begin
         checkOutput("idle_waddr", int'(waddr), (te + 1) % ENTRIES);
         applyStimulus(1'b1, 1'b0, '0, '0);
         checkOutput("restart_waddr", int'(waddr), 0);
      end
   endtask

   initial begin
      rst = 1'b1; wrt_smpl = 1'b0; run = 1'b0; capture_done = 1'b0; triggered = 1'b0;
      trig_posH = '0; trig_posL = '0; ch_en = '0; auto_rearm = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      started = 1'b1;
      checkOutput("rst_waddr", int'(waddr), 0);
      checkOutput("rst_armed", int'(armed), 0);
      checkOutput("rst_pulse", int'(set_capture_done), 0);
      checkOutput("rst_trace_end", int'(trace_end), 0);
      checkOutput("rst_we", int'(we), 0);
      rst = 1'b0;

      vecs[0] = '{16'h0080, 5'h1F,    300, 256, 428,  43, 1'b1};
      vecs[1] = '{16'h00C8, 5'b00101,   0, 184, 384, 383, 1'b0};
      vecs[2] = '{16'h0200, 5'b00101,  10,   1, 393,   8, 1'b1};
      vecs[3] = '{16'h0000, 5'b10010, 390, 383, 391,   6, 1'b1};
      vecs[4] = '{16'hFFFF, 5'b01000,   0,   1, 384, 383, 1'b0};

      setParams(vecs[0].trig_pos, vecs[0].ch_mask);
      run = 1'b1;
      applyStimulus(1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 5; i++) begin
         runCapture(vecs[i]);
         if (i < 4)
            setParams(vecs[i+1].trig_pos, vecs[i+1].ch_mask);
         else
            setParams(16'h0004, 5'h1F);
         handshake(vecs[i].rearm, vecs[i].trace_end_exp);
      end

      // Abort in POST: pre depth 380, trigger taken on write 380, run drops two post samples in.
      for (int k = 0; k < 382; k++)
         applyStimulus(1'b1, 1'b1, 5'h1F, AW'(k));
      checkOutput("abort_armed_before", int'(armed), 1);
      run = 1'b0;
      applyStimulus(1'b1, 1'b1, '0, '0);
      checkOutput("abort_armed", int'(armed), 0);
      checkOutput("abort_pulse", int'(set_capture_done), 0);
      checkOutput("abort_trace_end", int'(trace_end), 383);
      applyStimulus(1'b1, 1'b1, '0, '0);
      checkOutput("abort_pulse_late", int'(set_capture_done), 0);
      checkOutput("abort_waddr", int'(waddr), 382);

      // Reset mid-ARMED clears everything without waiting for a clock edge.
      setParams(16'h0200, 5'h1F);
      run = 1'b1;
      applyStimulus(1'b0, 1'b0, '0, '0);
      applyStimulus(1'b1, 1'b0, 5'h1F, 9'd0);
      checkOutput("rst_seq_armed", int'(armed), 1);
      applyStimulus(1'b1, 1'b0, 5'h1F, 9'd1);
      applyStimulus(1'b1, 1'b0, 5'h1F, 9'd2);
      wrt_smpl = 1'b1;
      rst      = 1'b1;
      #1;
      checkOutput("async_rst_waddr", int'(waddr), 0);
      checkOutput("async_rst_armed", int'(armed), 0);
      checkOutput("async_rst_we", int'(we), 0);
      checkOutput("async_rst_trace_end", int'(trace_end), 0);
      checkOutput("async_rst_pulse", int'(set_capture_done), 0);
      @(posedge clk);
      #1;
      run      = 1'b0;
      wrt_smpl = 1'b0;
      rst      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("sb_drained", sb_queue.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
